// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: next-PC select codes, fetch FSM state encoding, NOP word, PC increment.
// Imported by the fetch stage, its adder and the testbench.
package if_stage_pkg;

  // Next-PC select codes driven back from decode
  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  // Fetch FSM: FETCH requests and consumes, DISCARD drains a fetch made stale by a
  // redirect, HOLD parks a word fetched while the pipeline was stalled.
  typedef enum logic [1:0] {
    IF_FETCH   = 2'b00,
    IF_DISCARD = 2'b01,
    IF_HOLD    = 2'b10
  } if_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack handshake plus the IF/ID register.
// master = fetch stage (drives imem_req/imem_addr and IF/ID), slave = memory + decode side.
// imem_addr is stable while imem_req=1; imem_rdata is meaningful only with imem_ack=1.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    output imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
    input  imem_rdata, imem_ack
  );

  modport slave (
    input  imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
    output imem_rdata, imem_ack
  );
endinterface

// File: rtl/if_stage_adder.sv
// Plain 32-bit adder, used for pc+4; the carry out is dropped so the sum wraps mod 2^32.
// Ports: i_a, i_b operands; o_sum result.
// Purely combinational.
module if_stage_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, fetches over imem req/ack, fills the IF/ID register.
// Ports: i_clk/i_rst (sync, active-high), i_stall, i_flush, i_pc_src + targets from decode,
//   o_pc_out (debug PC), bus (if_stage_if.master: imem handshake and IF/ID outputs).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_branch_adr,
  input  logic [31:0] i_jump_adr,
  input  logic [31:0] i_jr_adr,
  output logic [31:0] o_pc_out,
  if_stage_if.master  bus
);

  if_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_saved_tgt;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_ack;

  if_stage_adder u_pc_adder (
    .i_a   (r_pc),
    .i_b   (PC_STEP),
    .o_sum (w_pc_plus4)
  );

  // A flush with pc_src=00 only squashes; fetch continues at pc+4.
  always_comb begin
    w_target = w_pc_plus4;
    case (i_pc_src)
      PCSRC_NEXT:   w_target = w_pc_plus4;
      PCSRC_BRANCH: w_target = i_branch_adr;
      PCSRC_JUMP:   w_target = i_jump_adr;
      PCSRC_JR:     w_target = i_jr_adr;
      default:      w_target = w_pc_plus4;
    endcase
  end

  assign w_redirect = (i_pc_src != PCSRC_NEXT) | i_flush;

  // Requests are never aborted, so the address is simply the PC, which only moves on ack.
  assign bus.imem_req  = (r_state != IF_HOLD) & ~i_rst;
  assign bus.imem_addr = r_pc;
  // Ignore a stray ack that arrives while nothing is outstanding.
  assign w_ack         = bus.imem_ack & bus.imem_req;

  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_valid = r_if_id_valid;
  assign o_pc_out        = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IF_FETCH;
      r_pc          <= RESET_PC;
      r_hold_buf    <= NOP;
      r_saved_tgt   <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= NOP;
      r_if_id_valid <= 1'b0;
    end else begin
      case (r_state)
        IF_FETCH: begin
          if (i_stall) begin
            // IF/ID frozen; park a word that completes now so the request can drop.
            if (w_ack) begin
              r_hold_buf <= bus.imem_rdata;
              r_state    <= IF_HOLD;
            end
          end else if (w_redirect) begin
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= NOP;
            r_if_id_valid <= 1'b0;
            if (w_ack) begin
              r_pc <= w_target;
            end else begin
              // Can't abandon the request: remember where to go once it drains.
              r_saved_tgt <= w_target;
              r_state     <= IF_DISCARD;
            end
          end else if (w_ack) begin
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= bus.imem_rdata;
            r_if_id_valid <= 1'b1;
            r_pc          <= w_pc_plus4;
          end else begin
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= NOP;
            r_if_id_valid <= 1'b0;
          end
        end

        IF_DISCARD: begin
          // IF/ID already holds a bubble. A flush-only squash carries no new target,
          // so it must not replace the pending branch/jump destination.
          if (w_ack) begin
            r_pc    <= (!i_stall && (i_pc_src != PCSRC_NEXT)) ? w_target : r_saved_tgt;
            r_state <= IF_FETCH;
          end else if (!i_stall && (i_pc_src != PCSRC_NEXT)) begin
            r_saved_tgt <= w_target;
          end
        end

        IF_HOLD: begin
          if (!i_stall) begin
            r_state    <= IF_FETCH;
            r_if_id_pc <= w_pc_plus4;
            if (w_redirect) begin
              r_if_id_instr <= NOP;
              r_if_id_valid <= 1'b0;
              r_pc          <= w_target;
            end else begin
              r_if_id_instr <= r_hold_buf;
              r_if_id_valid <= 1'b1;
              r_pc          <= w_pc_plus4;
            end
          end
        end

        default: r_state <= IF_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory of configurable ack latency.
// Memory word at address a is 32'hA500_0000 ^ a, so expected instructions are hand-computable.
// Inputs change 1ns after the rising edge; outputs are checked at that point too.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_adr;
  logic [31:0] jump_adr;
  logic [31:0] jr_adr;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt    = 0;

  if_stage_if u_bus ();

  if_stage #(.RESET_PC(32'h0), .NOP(32'h0)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_pc_src     (pc_src),
    .i_branch_adr (branch_adr),
    .i_jump_adr   (jump_adr),
    .i_jr_adr     (jr_adr),
    .o_pc_out     (pc_out),
    .bus          (u_bus.master)
  );

  always #5 clk = ~clk;

  // Memory: ack in the lat-th cycle of a request (lat=1 is same-cycle ack).
  assign u_bus.imem_ack   = u_bus.imem_req && (cnt == lat - 1);
  assign u_bus.imem_rdata = 32'hA500_0000 ^ u_bus.imem_addr;

  always @(posedge clk) begin
    if (!u_bus.imem_req || u_bus.imem_ack) cnt <= 0;
    else                                    cnt <= cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int new_lat);
    rst    = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    pc_src = PCSRC_NEXT;
    lat    = new_lat;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    branch_adr = 32'h0;
    jump_adr   = 32'h0;
    jr_adr     = 32'h0;

    // ---- reset state ----
    do_reset(1);
    rst = 1'b1;
    #1;
    check_val("rst_req", {31'b0, u_bus.imem_req}, 32'h0);
    check_val("rst_valid", {31'b0, u_bus.if_id_valid}, 32'h0);
    check_val("rst_instr", u_bus.if_id_instr, 32'h0);
    check_val("rst_ifid_pc", u_bus.if_id_pc, 32'h0);
    check_val("rst_pc", pc_out, 32'h0);
    rst = 1'b0;
    #1;

    // ---- 1: zero-wait, one instruction per cycle ----
    check_val("t1_addr0", u_bus.imem_addr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("t1_pc", u_bus.if_id_pc, 32'(4 * i));
      check_val("t1_instr", u_bus.if_id_instr, 32'hA500_0000 ^ 32'(4 * (i - 1)));
      check_val("t1_valid", {31'b0, u_bus.if_id_valid}, 32'h1);
    end

    // ---- 2: 3-cycle memory, two bubbles per instruction, stable address ----
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) begin
        tick();
        check_val("t2_bubble", {31'b0, u_bus.if_id_valid}, 32'h0);
        check_val("t2_addr", u_bus.imem_addr, 32'hC + 32'(4 * k));
        check_val("t2_req", {31'b0, u_bus.imem_req}, 32'h1);
      end
      tick();
      check_val("t2_valid", {31'b0, u_bus.if_id_valid}, 32'h1);
      check_val("t2_pc", u_bus.if_id_pc, 32'h10 + 32'(4 * k));
      check_val("t2_instr", u_bus.if_id_instr, 32'hA500_000C + 32'(4 * k));
    end

    // ---- 3: branch taken with ack in the same cycle ----
    do_reset(1);
    run(4);
    check_val("t3_addr", u_bus.imem_addr, 32'h10);
    pc_src = PCSRC_BRANCH;
    branch_adr = 32'h40;
    tick();
    pc_src = PCSRC_NEXT;
    check_val("t3_bubble", {31'b0, u_bus.if_id_valid}, 32'h0);
    check_val("t3_nop", u_bus.if_id_instr, 32'h0);
    check_val("t3_addr_tgt", u_bus.imem_addr, 32'h40);
    tick();
    check_val("t3_pc", u_bus.if_id_pc, 32'h44);
    check_val("t3_instr", u_bus.if_id_instr, 32'hA500_0040);
    check_val("t3_valid", {31'b0, u_bus.if_id_valid}, 32'h1);

    // ---- 4: jump while a slow fetch is outstanding ----
    do_reset(1);
    run(8);
    lat = 3;
    check_val("t4_addr", u_bus.imem_addr, 32'h20);
    pc_src = PCSRC_JUMP;
    jump_adr = 32'h80;
    tick();
    pc_src = PCSRC_NEXT;
    check_val("t4_bubble", {31'b0, u_bus.if_id_valid}, 32'h0);
    check_val("t4_addr_hold1", u_bus.imem_addr, 32'h20);
    check_val("t4_req1", {31'b0, u_bus.imem_req}, 32'h1);
    tick();
    check_val("t4_addr_hold2", u_bus.imem_addr, 32'h20);
    tick();
    check_val("t4_addr_tgt", u_bus.imem_addr, 32'h80);
    check_val("t4_dropped", {31'b0, u_bus.if_id_valid}, 32'h0);
    lat = 1;
    tick();
    check_val("t4_pc", u_bus.if_id_pc, 32'h84);
    check_val("t4_instr", u_bus.if_id_instr, 32'hA500_0080);

    // ---- 5: stall for 4 cycles as ack arrives for 0x30 ----
    do_reset(1);
    run(12);
    check_val("t5_addr", u_bus.imem_addr, 32'h30);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t5_req_off", {31'b0, u_bus.imem_req}, 32'h0);
      check_val("t5_frozen_pc", u_bus.if_id_pc, 32'h30);
      check_val("t5_frozen_instr", u_bus.if_id_instr, 32'hA500_002C);
      check_val("t5_pc_out", pc_out, 32'h30);
    end
    stall = 1'b0;
    tick();
    check_val("t5_pc", u_bus.if_id_pc, 32'h34);
    check_val("t5_instr", u_bus.if_id_instr, 32'hA500_0030);
    check_val("t5_valid", {31'b0, u_bus.if_id_valid}, 32'h1);
    check_val("t5_addr_next", u_bus.imem_addr, 32'h34);
    check_val("t5_req_on", {31'b0, u_bus.imem_req}, 32'h1);

    // ---- 6: reset while in DISCARD with a saved target ----
    do_reset(3);
    pc_src = PCSRC_JR;
    jr_adr = 32'h100;
    tick();
    pc_src = PCSRC_NEXT;
    check_val("t6_discard_addr", u_bus.imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    check_val("t6_req_rst", {31'b0, u_bus.imem_req}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_val("t6_req", {31'b0, u_bus.imem_req}, 32'h1);
    check_val("t6_addr", u_bus.imem_addr, 32'h0);
    check_val("t6_valid", {31'b0, u_bus.if_id_valid}, 32'h0);
    check_val("t6_instr", u_bus.if_id_instr, 32'h0);
    run(3);
    check_val("t6_first_pc", u_bus.if_id_pc, 32'h4);
    check_val("t6_first_instr", u_bus.if_id_instr, 32'hA500_0000);

    // ---- PC wrap: jr to 0xFFFFFFFC, pc+4 wraps to 0 ----
    do_reset(1);
    pc_src = PCSRC_JR;
    jr_adr = 32'hFFFF_FFFC;
    tick();
    pc_src = PCSRC_NEXT;
    check_val("wrap_addr", u_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_val("wrap_pc", u_bus.if_id_pc, 32'h0);
    check_val("wrap_instr", u_bus.if_id_instr, 32'h5AFF_FFFC);
    check_val("wrap_next_addr", u_bus.imem_addr, 32'h0);

    // ---- flush only: squash, continue sequentially ----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_bubble", {31'b0, u_bus.if_id_valid}, 32'h0);
    check_val("flush_addr", u_bus.imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
